alu_interface: RTL and testbench
================================

# alu_interface

Sequencing stage directly upstream of the ALU. It takes bytes from the UART receiver and loads them into the ALU's shared entry bus in the order operand A, operand B, opcode, using one-hot load enables. It then waits for the ALU result and returns it to the UART transmitter as two bytes: the result, then a carry byte. It is the only block that drives the ALU's `entry_bus` and `enables`.

## Interface
- `DATA_BUS`, 8, width of data bytes and ALU operands
- `OP_BUS`, 6, significant opcode bits; upper `DATA_BUS-OP_BUS` bits of an opcode byte must be zero
- `DONE_TIMEOUT`, 16, cycles to wait for `calc_done` before capturing the result anyway

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `rx_data` in DATA_BUS: received byte, valid when `rx_done`=1
- `rx_done` in 1: one-cycle pulse per received byte
- `result_bus` in DATA_BUS: ALU result
- `carry` in 1: ALU carry-out
- `calc_done` in 1: ALU result-updated pulse
- `tx_done` in 1: one-cycle pulse when the transmitter finishes a byte
- `entry_bus` out DATA_BUS: byte presented to the ALU
- `enables` out 3: one-hot load strobe; [0]=A, [1]=B, [2]=opcode
- `tx_data` out DATA_BUS: byte to transmit
- `tx_start` out 1: one-cycle transmit request
- `busy` out 1: high in every state except GET_A
- `err_opcode` out 1: sticky invalid-opcode flag, cleared by the next accepted A byte

## Operation
- States:
  - GET_A → GET_B → GET_OP → LOAD_OP → WAIT_RES → SEND_RES → WAIT_TX_RES → SEND_CARRY → WAIT_TX_CARRY → GET_A
  - Invalid opcode path: GET_OP → GET_A
- GET_A, GET_B:
  - On `rx_done`, register `entry_bus<=rx_data` and pulse the matching `enables` bit for one cycle.
  - Advance to the next state.
- GET_OP, on `rx_done`:
  - Valid opcode set: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA, 0x02 SRL.
  - Valid opcode: drive `entry_bus<=rx_data`, go to LOAD_OP.
  - Invalid opcode, or nonzero upper bits: set `err_opcode`, do not strobe `enables[2]`, return to GET_A, transmit nothing.
- LOAD_OP:
  - Hold `enables=3'b100` for exactly 2 consecutive cycles. The ALU evaluates its previously latched opcode, so the second cycle guarantees the new opcode is used.
  - Go to WAIT_RES.
- WAIT_RES:
  - Capture `result_bus` and `carry` into internal registers on the first cycle `calc_done`=1.
  - Otherwise capture when the timer reaches `DONE_TIMEOUT`. This covers the case where the result equals the previous one and no `calc_done` pulse occurs.
- SEND_RES: `tx_data<=result`, pulse `tx_start`.
- SEND_CARRY: `tx_data<={{DATA_BUS-1{1'b0}},carry}`, pulse `tx_start`.
- WAIT_TX_RES, WAIT_TX_CARRY: advance only on `tx_done`.
- Ignored events:
  - `rx_done` in any state other than GET_A/GET_B/GET_OP is dropped.
  - `tx_done` outside the WAIT_TX states is ignored.
  - `calc_done` outside WAIT_RES is ignored.
- `enables` is never more than one-hot and is zero outside its strobe cycles.

## Timing
- All outputs are registered. The timeout counter is `$clog2(DONE_TIMEOUT+1)` bits, cleared on WAIT_RES entry, and saturates.
- Reset values:
  - State GET_A.
  - `entry_bus`=0, `enables`=0, `tx_data`=0, `tx_start`=0, `busy`=0, `err_opcode`=0.
  - Captured result and carry = 0.
  - Timer = 0.
- Latencies:
  - `rx_done` at cycle t (A or B) → enable bit high at t+1 only, with `entry_bus` valid from t+1 and held until the next load.
  - Opcode `rx_done` at t → `enables[2]` high at t+1 and t+2; WAIT_RES from t+3.
  - Capture at cycle c → `tx_start` at c+1.
  - `tx_done` at d (result byte) → carry `tx_start` at d+1.
  - `tx_done` for the carry byte at e → GET_A at e+1.
- Mid-operation reset: `rst_n` low in any state forces all outputs to reset values immediately. No partial byte is retransmitted after release.
- `calc_done` and the timeout reached in the same cycle: treated as `calc_done`; the capture is identical.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams (ADD_OP … SRL_OP)
  - Enable bit indices (EN_A=0, EN_B=1, EN_OP=2)
  - State encoding
  - Function `is_valid_op(byte)`
- The ALU imports the same opcode constants.
- No sub-module: FSM and timer are inline, single file.

## Test plan
- Rx bytes 0x05, 0x03, 0x20, ALU model pulses `calc_done` → `enables` sequence 001, 010, 100, 100; tx 0x08 then 0x01? no — tx 0x08 then 0x00.
- Rx 0xFF, 0x01, 0x20 → tx 0x00 then 0x01 (carry).
- Rx 0x03, 0x05, 0x22 → tx 0xFE then 0x00.
- Rx 0x05, 0x03, 0x21 → `err_opcode`=1, `enables[2]` never set, no `tx_start`. Next frame clears `err_opcode`.
- Repeat the same ADD frame with `calc_done` held low → `tx_start` exactly `DONE_TIMEOUT`+1 cycles after WAIT_RES entry, tx 0x08, 0x00.
- `rst_n` pulsed low during WAIT_TX_RES, extra `rx_done` injected during WAIT_RES → all outputs 0 during reset, the stray byte is ignored, and the following full frame completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, load-enable indices and sequencer states
package alu_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] ADD_OP = 6'h20;
    localparam logic [OP_W-1:0] SUB_OP = 6'h22;
    localparam logic [OP_W-1:0] AND_OP = 6'h24;
    localparam logic [OP_W-1:0] OR_OP  = 6'h25;
    localparam logic [OP_W-1:0] XOR_OP = 6'h26;
    localparam logic [OP_W-1:0] NOR_OP = 6'h27;
    localparam logic [OP_W-1:0] SRA_OP = 6'h03;
    localparam logic [OP_W-1:0] SRL_OP = 6'h02;

    localparam int EN_A  = 0;
    localparam int EN_B  = 1;
    localparam int EN_OP = 2;

    typedef enum logic [3:0] {
        GET_A,
        GET_B,
        GET_OP,
        LOAD_OP,
        WAIT_RES,
        SEND_RES,
        WAIT_TX_RES,
        SEND_CARRY,
        WAIT_TX_CARRY
    } state_t;

    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        case (op)
            ADD_OP, SUB_OP, AND_OP, OR_OP,
            XOR_OP, NOR_OP, SRA_OP, SRL_OP: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_interface.sv
// rtl/alu_interface.sv - sequences UART bytes into the ALU and returns result and carry
module alu_interface
    import alu_pkg::*;
#(
    parameter int DATA_BUS     = 8,
    parameter int OP_BUS       = 6,
    parameter int DONE_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_BUS-1:0] rx_data,
    input  logic                rx_done,
    input  logic [DATA_BUS-1:0] result_bus,
    input  logic                carry,
    input  logic                calc_done,
    input  logic                tx_done,
    output logic [DATA_BUS-1:0] entry_bus,
    output logic [2:0]          enables,
    output logic [DATA_BUS-1:0] tx_data,
    output logic                tx_start,
    output logic                busy,
    output logic                err_opcode
);

    localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);

    state_t              state, state_d;
    logic                load_second, load_second_d;
    logic [TMR_W-1:0]    timer, timer_d;
    logic [DATA_BUS-1:0] result_q, result_d;
    logic                carry_q, carry_d;
    logic [DATA_BUS-1:0] entry_bus_d, tx_data_d;
    logic [2:0]          enables_d;
    logic                tx_start_d, busy_d, err_d;
    logic                op_ok, timed_out;

    assign op_ok     = (rx_data[DATA_BUS-1:OP_BUS] == '0) && is_valid_op(rx_data[OP_BUS-1:0]);
    assign timed_out = (timer == TMR_W'(DONE_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= GET_A;
            load_second <= 1'b0;
            timer       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            entry_bus   <= '0;
            enables     <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            err_opcode  <= 1'b0;
        end else begin
            state       <= state_d;
            load_second <= load_second_d;
            timer       <= timer_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            entry_bus   <= entry_bus_d;
            enables     <= enables_d;
            tx_data     <= tx_data_d;
            tx_start    <= tx_start_d;
            busy        <= busy_d;
            err_opcode  <= err_d;
        end
    end

    always_comb begin
        state_d       = state;
        load_second_d = load_second;
        timer_d       = timer;
        result_d      = result_q;
        carry_d       = carry_q;
        entry_bus_d   = entry_bus;
        tx_data_d     = tx_data;
        enables_d     = '0;
        tx_start_d    = 1'b0;
        err_d         = err_opcode;
        case (state)
            GET_A: if (rx_done) begin
                entry_bus_d      = rx_data;
                enables_d[EN_A]  = 1'b1;
                err_d            = 1'b0;
                state_d          = GET_B;
            end
            GET_B: if (rx_done) begin
                entry_bus_d      = rx_data;
                enables_d[EN_B]  = 1'b1;
                state_d          = GET_OP;
            end
            GET_OP: if (rx_done) begin
                if (op_ok) begin
                    entry_bus_d      = rx_data;
                    enables_d[EN_OP] = 1'b1;
                    load_second_d    = 1'b0;
                    state_d          = LOAD_OP;
                end else begin
                    err_d   = 1'b1;
                    state_d = GET_A;
                end
            end
            // The ALU acts on its previously latched opcode, so strobe it twice.
            LOAD_OP: begin
                if (!load_second) begin
                    enables_d[EN_OP] = 1'b1;
                    load_second_d    = 1'b1;
                end else begin
                    timer_d = '0;
                    state_d = WAIT_RES;
                end
            end
            // An unchanged result produces no calc_done, hence the timeout capture.
            WAIT_RES: begin
                if (calc_done || timed_out) begin
                    result_d   = result_bus;
                    carry_d    = carry;
                    tx_data_d  = result_bus;
                    tx_start_d = 1'b1;
                    state_d    = SEND_RES;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            SEND_RES: begin
                tx_data_d = result_q;
                state_d   = WAIT_TX_RES;
            end
            WAIT_TX_RES: if (tx_done) begin
                tx_data_d  = {{DATA_BUS-1{1'b0}}, carry_q};
                tx_start_d = 1'b1;
                state_d    = SEND_CARRY;
            end
            SEND_CARRY: state_d = WAIT_TX_CARRY;
            WAIT_TX_CARRY: if (tx_done) state_d = GET_A;
            default: state_d = GET_A;
        endcase
        busy_d = (state_d != GET_A);
    end

endmodule

// File: tb/tb_alu_interface.sv
// tb/tb_alu_interface.sv - randomized and directed checks of alu_interface against a byte-level model
module tb_alu_interface;

    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_done = 1'b0;
    logic [DW-1:0] result_bus = '0;
    logic          carry = 1'b0;
    logic          calc_done = 1'b0;
    logic          tx_done = 1'b0;
    logic [DW-1:0] entry_bus;
    logic [2:0]    enables;
    logic [DW-1:0] tx_data;
    logic          tx_start;
    logic          busy;
    logic          err_opcode;

    always #5 clk = ~clk;

    alu_interface #(.DATA_BUS(DW), .OP_BUS(6), .DONE_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
        .result_bus(result_bus), .carry(carry), .calc_done(calc_done), .tx_done(tx_done),
        .entry_bus(entry_bus), .enables(enables), .tx_data(tx_data), .tx_start(tx_start),
        .busy(busy), .err_opcode(err_opcode)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] valid_ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    function automatic bit op_is_valid(input logic [7:0] op);
        foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // {carry, result} of the ALU; only ADD produces a carry.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        case (op)
            8'h20:   return {1'b0, a} + {1'b0, b};
            8'h22:   return {1'b0, 8'(a - b)};
            8'h24:   return {1'b0, a & b};
            8'h25:   return {1'b0, a | b};
            8'h26:   return {1'b0, a ^ b};
            8'h27:   return {1'b0, ~(a | b)};
            8'h03:   return {1'b0, 8'($signed(a) >>> b[2:0])};
            8'h02:   return {1'b0, a >> b[2:0]};
            default: return 9'h000;
        endcase
    endfunction

    logic [7:0] alu_a = '0, alu_b = '0, alu_op = '0;
    bit         done_en = 1'b1;

    always @(posedge clk) begin : alu_model
        logic [8:0] r;
        if (enables[0]) alu_a <= entry_bus;
        if (enables[1]) alu_b <= entry_bus;
        if (enables[2]) alu_op <= entry_bus;
        r = alu_f(alu_a, alu_b, alu_op);
        result_bus <= r[7:0];
        carry      <= r[8];
        calc_done  <= done_en && (r != {carry, result_bus});
    end

    int tx_cnt = 0;
    always @(posedge clk) begin : uart_tx_model
        tx_done <= 1'b0;
        if (!rst_n) tx_cnt <= 0;
        else if (tx_start) tx_cnt <= 3;
        else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_done <= 1'b1;
        end
    end

    int         cyc = 0;
    int         rx_cyc_q [$];
    logic [7:0] tx_q [$];
    int         tx_cyc_q [$];
    logic [2:0] en_q [$];
    int         en_cyc_q [$];

    always @(negedge clk) begin
        cyc++;
        if (rx_done) rx_cyc_q.push_back(cyc);
        if (tx_start) begin
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
        end
        if (enables != 3'b000) begin
            en_q.push_back(enables);
            en_cyc_q.push_back(cyc);
            check("enables_onehot", $countones(enables), 1);
        end
    end

    task automatic send_byte(input logic [7:0] d);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 rx_data = d;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic wait_idle(input int n_tx, input string tag);
        int k;
        k = 0;
        while ((tx_q.size() < n_tx || busy) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, " done_in_time"}, k < 300, 1);
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input string tag);
        int n0;
        logic [8:0] r;
        n0 = tx_q.size();
        r  = alu_f(a, b, op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_idle(n0 + 2, tag);
        check({tag, " tx_count"}, tx_q.size(), n0 + 2);
        check({tag, " tx_result"}, tx_q[n0], r[7:0]);
        check({tag, " tx_carry"}, tx_q[n0 + 1], {7'b0, r[8]});
        check({tag, " err_clear"}, err_opcode, 0);
    endtask

    task automatic run_bad(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input string tag);
        int n0, e0;
        n0 = tx_q.size();
        e0 = en_q.size();
        send_byte(a);
        send_byte(b);
        send_byte(op);
        repeat (25) @(posedge clk);
        #1;
        check({tag, " err_set"}, err_opcode, 1);
        check({tag, " no_tx"}, tx_q.size(), n0);
        check({tag, " only_ab_strobes"}, en_q.size(), e0 + 2);
        check({tag, " idle"}, busy, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " entry_bus"}, entry_bus, 0);
        check({tag, " enables"}, enables, 0);
        check({tag, " tx_data"}, tx_data, 0);
        check({tag, " tx_start"}, tx_start, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " err_opcode"}, err_opcode, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, r0, t0, n0, k;
        logic [7:0] a, b, op;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ADD with calc_done: strobe order, latencies and bytes
        e0 = en_q.size(); r0 = rx_cyc_q.size(); t0 = tx_cyc_q.size();
        run_frame(8'h05, 8'h03, 8'h20, "add");
        check("add en0", en_q[e0], 3'b001);
        check("add en1", en_q[e0 + 1], 3'b010);
        check("add en2", en_q[e0 + 2], 3'b100);
        check("add en3", en_q[e0 + 3], 3'b100);
        check("add en_count", en_q.size(), e0 + 4);
        check("add lat_a", en_cyc_q[e0] - rx_cyc_q[r0], 1);
        check("add lat_b", en_cyc_q[e0 + 1] - rx_cyc_q[r0 + 1], 1);
        check("add lat_op1", en_cyc_q[e0 + 2] - rx_cyc_q[r0 + 2], 1);
        check("add lat_op2", en_cyc_q[e0 + 3] - rx_cyc_q[r0 + 2], 2);
        check("add lat_tx", tx_cyc_q[t0] - rx_cyc_q[r0 + 2], 4);
        check("add byte0", tx_q[t0], 8'h08);
        check("add byte1", tx_q[t0 + 1], 8'h00);

        t0 = tx_q.size();
        run_frame(8'hFF, 8'h01, 8'h20, "add_carry");
        check("add_carry byte0", tx_q[t0], 8'h00);
        check("add_carry byte1", tx_q[t0 + 1], 8'h01);

        t0 = tx_q.size();
        run_frame(8'h03, 8'h05, 8'h22, "sub");
        check("sub byte0", tx_q[t0], 8'hFE);
        check("sub byte1", tx_q[t0 + 1], 8'h00);

        run_bad(8'h05, 8'h03, 8'h21, "bad_op");
        run_bad(8'h05, 8'h03, 8'h60, "bad_upper");
        run_frame(8'h05, 8'h03, 8'h20, "after_bad");

        // same ADD with calc_done suppressed: capture comes from the timeout
        done_en = 1'b0;
        r0 = rx_cyc_q.size(); t0 = tx_cyc_q.size();
        run_frame(8'h05, 8'h03, 8'h20, "timeout");
        check("timeout lat_tx", tx_cyc_q[t0] - rx_cyc_q[r0 + 2], 3 + TO + 1);
        check("timeout byte0", tx_q[t0], 8'h08);
        check("timeout byte1", tx_q[t0 + 1], 8'h00);
        done_en = 1'b1;

        // reset while waiting for the result byte to finish
        n0 = tx_q.size();
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h20);
        k = 0;
        while (tx_q.size() < n0 + 1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("rst first_byte_seen", k < 200, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("rst no_retransmit", tx_q.size(), n0 + 1);
        check("rst idle", busy, 0);

        // stray rx byte during WAIT_RES must be dropped
        done_en = 1'b0;
        n0 = tx_q.size();
        send_byte(8'h21);
        send_byte(8'h12);
        send_byte(8'h26);
        repeat (4) @(posedge clk);
        send_byte(8'h77);
        wait_idle(n0 + 2, "stray");
        check("stray byte0", tx_q[n0], 8'h33);
        check("stray byte1", tx_q[n0 + 1], 8'h00);
        done_en = 1'b1;
        run_frame(8'h40, 8'h02, 8'h02, "after_stray");

        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            done_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                do op = 8'($urandom); while (op_is_valid(op));
                run_bad(a, b, op, "rand_bad");
            end else begin
                op = valid_ops[$urandom_range(0, 7)];
                run_frame(a, b, op, "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
